// File: rtl/core_uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, default line rate and
// clock, and elaboration-time helpers.
package core_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned UART_BAUD   = 115200;
    localparam int unsigned CPU_FREQ_HZ = 50000000;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/core_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. One extra pointer bit separates
// the full and empty cases when the address bits match.
module core_uart_tx_fifo
    import core_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          push,
    input  logic [7:0]                    wr_data,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // Guard here as well so a misbehaving caller can never corrupt the pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/core_uart_tx.sv
// UART transmitter: 8N1/8N2, LSB first, idle-high line, fed from a byte FIFO.
// Frames are sent back to back with no idle gap while the FIFO holds data.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high, baud counter held at 0, waiting for a queued byte
//   ST_START | start bit (low) for one baud period
//   ST_DATA  | eight data bits, LSB first, one baud period each
//   ST_STOP  | STOP_BITS baud periods high; pops the next byte on the last cycle
module core_uart_tx
    import core_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CPU_FREQ_HZ,
    parameter int unsigned BAUD        = UART_BAUD,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned DIV       = baud_div(CLK_FREQ_HZ, BAUD);
    localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("core_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_depth_check
        $error("core_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("core_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e   state_q;
    tx_state_e   state_d;
    logic [31:0] baud_cnt_q;
    logic [31:0] baud_cnt_d;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  bit_cnt_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        txd_q;
    logic        busy_q;
    logic        rst_done_q;
    logic        pop;
    logic        baud_tick;

    logic [7:0]                  fifo_rd_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    core_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (tx_valid_i && tx_ready_o),
        .wr_data (tx_data_i),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // rst_done_q keeps ready low for the whole reset and the first edge after it.
    assign tx_ready_o   = rst_done_q && !fifo_full;
    assign fifo_level_o = fifo_level;
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign baud_tick    = (baud_cnt_q == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    // bit_cnt wraps to 0 after bit 7, ready to count stop bits.
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rd_data;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line and busy are registered from the current state, so both lag it by one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_START: txd_q <= 1'b0;
                ST_DATA:  txd_q <= shift_q[0];
                default:  txd_q <= 1'b1;
            endcase
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_core_uart_tx.sv
// Bench for core_uart_tx: three instances (DIV=10 1 stop, DIV=10 2 stop, DIV=8 1 stop)
// driven in turn; a serial decoder and expected-byte queue judge the line.
module tb_core_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data  [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       txd      [3];
    logic       busy     [3];
    logic [4:0] lvl      [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    core_uart_tx #(.CLK_FREQ_HZ(1152000), .BAUD(115200), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
        .tx_ready_o(tx_ready[0]), .txd_o(txd[0]), .busy_o(busy[0]), .fifo_level_o(lvl[0]));

    core_uart_tx #(.CLK_FREQ_HZ(1152000), .BAUD(115200), .FIFO_DEPTH(16), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
        .tx_ready_o(tx_ready[1]), .txd_o(txd[1]), .busy_o(busy[1]), .fifo_level_o(lvl[1]));

    core_uart_tx #(.CLK_FREQ_HZ(1000000), .BAUD(115200), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data[2]), .tx_valid_i(tx_valid[2]),
        .tx_ready_o(tx_ready[2]), .txd_o(txd[2]), .busy_o(busy[2]), .fifo_level_o(lvl[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic push_one(input int u, input logic [7:0] b);
        tx_data[u]  = b;
        tx_valid[u] = 1'b1;
        @(negedge clk);
        tx_valid[u] = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then follows one frame sample by sample.
    // shape_err counts samples that break the start/steady-bit/stop pattern; -1 = no start.
    task automatic rx_frame(input int u, input int div, input int nstop, input int budget,
                            output logic [7:0] data, output int start_cyc,
                            output int shape_err, output logic busy_last);
        int   waited;
        logic ref_bit;
        waited    = 0;
        data      = '0;
        shape_err = 0;
        start_cyc = -1;
        busy_last = 1'b0;
        while (txd[u] !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (txd[u] !== 1'b0) begin
            shape_err = -1;
            return;
        end
        start_cyc = cyc;
        for (int b = 0; b < 9 + nstop; b++) begin
            for (int c = 0; c < div; c++) begin
                if (b == 0) begin
                    ref_bit = 1'b0;
                end else if (b > 8) begin
                    ref_bit = 1'b1;
                end else begin
                    if (c == 0) data[b-1] = txd[u];
                    ref_bit = data[b-1];
                end
                if (txd[u] !== ref_bit) shape_err++;
                busy_last = busy[u];
                @(negedge clk);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        int         s, e, pe, lows;
        logic       bl;
        pe = cyc + 1;
        push_one(0, 8'h55);
        tx_data[0] = 8'hFF;
        check("single_level", lvl[0], 1);
        rx_frame(0, 10, 1, 50, d, s, e, bl);
        check("single_byte", d, 8'h55);
        check("single_shape", e, 0);
        check("single_latency", s - pe, 2);
        check("single_busy_last_cycle", bl, 1);
        check("single_busy_end", busy[0], 0);
        lows = 0;
        repeat (20) begin
            if (txd[0] !== 1'b1) lows++;
            @(negedge clk);
        end
        check("single_idle_high", lows, 0);
    endtask

    task automatic test_b2b();
        logic [7:0] d;
        logic [7:0] exp_q[$];
        int         s, s0, e, pe;
        logic       bl;
        exp_q = '{8'h48, 8'h69, 8'h0a};
        pe = cyc + 1;
        foreach (exp_q[i]) push_one(0, exp_q[i]);
        check("b2b_level", lvl[0], 2);
        s0 = 0;
        for (int i = 0; i < 3; i++) begin
            rx_frame(0, 10, 1, 60, d, s, e, bl);
            check("b2b_byte", d, exp_q.pop_front());
            check("b2b_shape", e, 0);
            if (i == 0) begin
                check("b2b_latency", s - pe, 2);
                s0 = s;
            end else begin
                check("b2b_gapless_start", s - s0, 100 * i);
            end
        end
        check("b2b_total_cycles", cyc - s0, 300);
        check("b2b_busy_end", busy[0], 0);
    endtask

    task automatic test_full();
        logic [7:0] bytes[20];
        logic [7:0] exp_q[$];
        int         base, step;
        base = $urandom_range(0, 255);
        step = 2 * $urandom_range(0, 127) + 1;
        for (int i = 0; i < 20; i++) begin
            bytes[i] = 8'(base + i * step);
            exp_q.push_back(bytes[i]);
        end
        fork
            begin : pusher
                int   idx, t;
                logic rdy, seen_full, seen_rec;
                idx = 0; t = 0; seen_full = 0; seen_rec = 0;
                while (idx < 20 && t < 4000) begin
                    tx_data[0]  = bytes[idx];
                    tx_valid[0] = 1'b1;
                    rdy = tx_ready[0];
                    if (!rdy && !seen_full) begin
                        seen_full = 1;
                        check("full_level", lvl[0], 16);
                        check("full_accepted", idx, 17);
                    end
                    if (rdy && seen_full && !seen_rec) begin
                        seen_rec = 1;
                        check("full_recover_level", lvl[0], 15);
                    end
                    @(negedge clk);
                    t++;
                    if (rdy) idx++;
                end
                tx_valid[0] = 1'b0;
                check("full_all_pushed", idx, 20);
                check("full_seen_full", seen_full, 1);
                check("full_seen_recover", seen_rec, 1);
            end
            begin : receiver
                logic [7:0] d;
                int         s, prev, e;
                logic       bl;
                prev = 0;
                for (int i = 0; i < 20; i++) begin
                    rx_frame(0, 10, 1, 300, d, s, e, bl);
                    check("full_byte", d, (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx);
                    check("full_shape", e, 0);
                    if (i > 0) check("full_gapless_start", s - prev, 100);
                    prev = s;
                end
            end
        join
        check("full_busy_end", busy[0], 0);
    endtask

    task automatic test_stop2();
        logic [7:0] d;
        logic [7:0] exp_q[$];
        int         s, s0, e, pe;
        logic       bl;
        exp_q = '{8'h1b, 8'h04};
        pe = cyc + 1;
        foreach (exp_q[i]) push_one(1, exp_q[i]);
        check("stop2_level", lvl[1], 1);
        s0 = 0;
        for (int i = 0; i < 2; i++) begin
            rx_frame(1, 10, 2, 60, d, s, e, bl);
            check("stop2_byte", d, exp_q.pop_front());
            check("stop2_shape", e, 0);
            if (i == 0) begin
                check("stop2_latency", s - pe, 2);
                s0 = s;
            end else begin
                check("stop2_frame_len", s - s0, 110);
            end
        end
        check("stop2_busy_end", busy[1], 0);
    endtask

    task automatic test_rst_mid();
        logic [7:0] d;
        int         s, e, pe, lows;
        logic       bl;
        pe = cyc + 1;
        push_one(0, 8'h00);
        for (int i = 0; i < 3; i++) push_one(0, 8'($urandom_range(1, 255)));
        s = pe + 2;
        while (cyc < s + 45) @(negedge clk);
        check("mid_txd_before_rst", txd[0], 0);
        check("mid_level_before_rst", lvl[0], 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", txd[0], 1);
        check("mid_rst_level", lvl[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_ready", tx_ready[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
        end
        check("mid_no_start_after_rst", lows, 0);
        check("mid_busy_after_rst", busy[0], 0);
        check("mid_ready_after_rst", tx_ready[0], 1);
        push_one(0, 8'h3c);
        rx_frame(0, 10, 1, 50, d, s, e, bl);
        check("mid_byte_after_rst", d, 8'h3c);
        check("mid_shape_after_rst", e, 0);
    endtask

    task automatic test_div8();
        logic [7:0] d;
        int         s, e, pe;
        logic       bl;
        pe = cyc + 1;
        push_one(2, 8'hA5);
        rx_frame(2, 8, 1, 50, d, s, e, bl);
        check("div8_byte", d, 8'hA5);
        check("div8_shape", e, 0);
        check("div8_latency", s - pe, 2);
        check("div8_frame_len", cyc - s, 80);
        check("div8_busy_end", busy[2], 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            tx_valid[u] = 1'b0;
            tx_data[u]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_txd", txd[0], 1);
        check("rst_ready", tx_ready[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_level", lvl[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", tx_ready[0], 1);
        repeat (5) @(negedge clk);
        test_single();
        test_b2b();
        test_full();
        test_stop2();
        test_rst_mid();
        test_div8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_uart_tx.md
Name: core_uart_tx

Overview:
- Synthesizable UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first, idle-high line.
- Sits on the SoC peripheral side and drives the txd pin. Its serial output is also the stimulus that the UART RX monitor bench model decodes.
- Bytes enter through a valid/ready push port into a small FIFO. A baud-timed FSM serializes them with no inter-frame gap.

Parameters:
- CLK_FREQ_HZ, 50000000, clk_i frequency. SoC builds pass CPU_FREQ_HZ.
- BAUD, 115200, line rate.
- FIFO_DEPTH, 16, byte FIFO entries. Must be a power of two, at least 2.
- STOP_BITS, 1, number of stop bits. Legal values are 1 and 2.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- tx_data_i  in  8  byte to send
- tx_valid_i  in  1  push request
- tx_ready_o  out  1  FIFO can accept a byte
- txd_o  out  1  serial line, registered
- busy_o  out  1  frame in progress, or FIFO non-empty
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Divisor: DIV = CLK_FREQ_HZ/BAUD, integer truncation, computed at elaboration. DIV must be at least 2; check this with an elaboration assertion.
- Baud counter: 32 bits, counts 0..DIV-1. It wraps only while the FSM is not IDLE and is held at 0 in IDLE.
- Reset values:
  - txd_o=1, tx_ready_o=0 while in reset and 1 after.
  - busy_o=0, fifo_level_o=0.
  - FSM in IDLE, FIFO pointers at 0.
- Push: a byte is accepted when tx_valid_i && tx_ready_o at a clk_i edge. tx_ready_o = !full, and it depends only on registered level.
  - A push while full is not possible, because ready is low.
  - Push and pop in the same cycle: level is unchanged, data ordering is preserved.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level != 0, pop the head into the shift register, clear bit_cnt, go to START. txd_o=0 from the next cycle.
  - START: txd_o=0 for exactly DIV cycles, then go to DATA.
  - DATA: txd_o = shift[0]. After each DIV cycles, shift right and increment the 3-bit bit_cnt. After bit 7's period, go to STOP.
  - STOP: txd_o=1 for STOP_BITS*DIV cycles.
    - In the final cycle, if level != 0, pop and go directly to START, giving zero idle gap between frames.
    - Otherwise go to IDLE.
- Frame length: exactly (9+STOP_BITS)*DIV cycles.
- Latency: a push into an empty FIFO with the FSM in IDLE at edge N gives level=1 after N. The pop happens at edge N+1, and txd_o falls after edge N+2.
- busy_o = (state != IDLE) || (level != 0), registered.
- Reset mid-frame: txd_o returns to 1 asynchronously, the FIFO is flushed, and the partial frame is dropped. There is no glitch low after reset release.
- tx_data_i is sampled only on an accepted push. Later changes to it do not affect queued bytes.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - default UART_BAUD 115200;
  - CPU_FREQ_HZ, taken from the SoC parameter header.
- One sub-module, core_uart_tx_fifo:
  - synchronous FIFO, width 8, parameter FIFO_DEPTH;
  - push/pop/full/empty/level interface;
  - extra pointer bit for full/empty.
- The FSM and baud counter stay in core_uart_tx.

Test Plan (CLK_FREQ_HZ=1152000, BAUD=115200, so DIV=10, unless stated otherwise):
- Single byte: push 0x55 while idle.
  - txd_o low 2 cycles after the push edge.
  - Bits 0,1,0,1,0,1,0,1 each held 10 cycles, then stop high for 10 cycles.
  - busy_o falls 100 cycles after the start bit began.
- Back-to-back: push 0x48, 0x69, 0x0a on consecutive cycles.
  - The bench decoder receives "Hi\n" in order.
  - Total 300 cycles from the first start edge, with no high gap between a stop bit and the next start bit.
- FIFO full: hold tx_valid_i with 20 distinct bytes while the line is busy.
  - tx_ready_o drops when level=16 and recovers after each pop.
  - All 20 bytes are decoded in order with none lost.
- STOP_BITS=2: push 0x1b then 0x04.
  - Each frame is 110 cycles with the stop high for 20 cycles.
  - The decoder sees 0x1b followed by 0x04.
- Reset mid-frame: assert rst_n_i at cycle 45 of a 0x00 frame, with 3 bytes queued.
  - txd_o=1 immediately, fifo_level_o=0, busy_o=0.
  - After release, no start bit until a new push.
- Divisor truncation: CLK_FREQ_HZ=1000000 (DIV=8). Push 0xA5; every bit is exactly 8 cycles.
